vga_timing_gen: RTL

Parametrised VGA raster timing generator for the display path: one combined horizontal/vertical scan counter driven by a pixel-enable tick. It produces pixel coordinates, sync pulses with programmable polarity, a video-active flag, and line/frame strobes for the cell renderer and the generation-update logic. It replaces the standalone vertical counter. All porch and sync widths are parameters. Both counters wrap exactly at their total (0..TOTAL-1). Every output is registered and aligned to the coordinates.

---
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v scan counters, syncs, video_on, strobes.
// Optional frame counter output under `VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_end,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic          frame_end,
    output logic [15:0]   frame_count
`else
    output logic          frame_end
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_A_END = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] H_F_END = CW'(H_ACTIVE + H_FP - 1);
    localparam logic [CW-1:0] H_S_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_A_END = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] V_F_END = CW'(V_ACTIVE + V_FP - 1);
    localparam logic [CW-1:0] V_S_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);

    typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC_S, H_BACK} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC_S, V_BACK} v_state_t;

    h_state_t      h_st, h_st_nxt;
    v_state_t      v_st, v_st_nxt;
    logic [CW-1:0] h_nxt, v_nxt;
    logic          wrap;

    assign wrap = (h_count == H_LAST);

    // Zero-length porches are skipped by jumping straight past them.
    always_comb begin
        h_nxt    = h_count;
        v_nxt    = v_count;
        h_st_nxt = h_st;
        v_st_nxt = v_st;
        if (pix_en) begin
            h_nxt = wrap ? '0 : h_count + CW'(1);
            unique case (h_st)
                H_ACT:
                    if (h_count == H_A_END)
                        h_st_nxt = (H_FP != 0) ? H_FRONT : H_SYNC_S;
                H_FRONT:
                    if (h_count == H_F_END) h_st_nxt = H_SYNC_S;
                H_SYNC_S:
                    if (h_count == H_S_END)
                        h_st_nxt = (H_BP != 0) ? H_BACK : H_ACT;
                H_BACK:
                    if (wrap) h_st_nxt = H_ACT;
            endcase
            if (wrap) begin
                v_nxt = (v_count == V_LAST) ? '0 : v_count + CW'(1);
                unique case (v_st)
                    V_ACT:
                        if (v_count == V_A_END)
                            v_st_nxt = (V_FP != 0) ? V_FRONT : V_SYNC_S;
                    V_FRONT:
                        if (v_count == V_F_END) v_st_nxt = V_SYNC_S;
                    V_SYNC_S:
                        if (v_count == V_S_END)
                            v_st_nxt = (V_BP != 0) ? V_BACK : V_ACT;
                    V_BACK:
                        if (v_count == V_LAST) v_st_nxt = V_ACT;
                endcase
            end
        end
    end

    // Flags come from next-state values so they stay aligned to the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count   <= '0;
            v_count   <= '0;
            h_st      <= H_ACT;
            v_st      <= V_ACT;
            hsync     <= ~HS_POL;
            vsync     <= ~VS_POL;
            video_on  <= 1'b1;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else if (pix_en) begin
            h_count   <= h_nxt;
            v_count   <= v_nxt;
            h_st      <= h_st_nxt;
            v_st      <= v_st_nxt;
            hsync     <= (h_st_nxt == H_SYNC_S) ? HS_POL : ~HS_POL;
            vsync     <= (v_st_nxt == V_SYNC_S) ? VS_POL : ~VS_POL;
            video_on  <= (h_st_nxt == H_ACT) && (v_st_nxt == V_ACT);
            line_end  <= (h_nxt == H_LAST);
            frame_end <= (h_nxt == H_LAST) && (v_nxt == V_LAST);
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_count <= 16'd0;
        else if (pix_en && frame_end)
            frame_count <= frame_count + 16'd1;
    end
`endif

endmodule
